// File: rtl/mem_port_arbiter.sv
// Shares one memory bus between instruction fetch and the load/store stage.
// Round-robin on ties; one transfer in flight; ready pulses mark completion.
module mem_port_arbiter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    output logic [XLEN-1:0] if_rdata,
    output logic            if_ready,
    input  logic            d_req,
    input  logic            d_we,
    input  logic [3:0]      d_wstrb,
    input  logic [XLEN-1:0] d_addr,
    input  logic [XLEN-1:0] d_wdata,
    output logic [XLEN-1:0] d_rdata,
    output logic            d_ready,
    output logic            bus_valid,
    output logic [XLEN-1:0] bus_addr,
    output logic            bus_we,
    output logic [3:0]      bus_wstrb,
    output logic [XLEN-1:0] bus_wdata,
    input  logic            bus_ready,
    input  logic [XLEN-1:0] bus_rdata,
    output logic            stall_fetch,
    output logic            stall_mem
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DATA
    } state_t;

    typedef enum logic {
        GNT_F,
        GNT_D
    } grant_t;

    state_t          state, state_n;
    grant_t          last, last_n;
    logic [XLEN-1:0] addr_n, wdata_n;
    logic [XLEN-1:0] if_rdata_n, d_rdata_n;
    logic [3:0]      wstrb_n;
    logic            we_n;
    logic            if_ready_n, d_ready_n;
    logic            if_elig, d_elig;

    // A requester being acknowledged this cycle must not be re-granted.
    assign if_elig = if_req & ~if_ready;
    assign d_elig  = d_req & ~d_ready;

    assign bus_valid   = (state != IDLE);
    assign stall_fetch = if_req & ~if_ready;
    assign stall_mem   = d_req & ~d_ready;

    always_comb begin
        state_n    = state;
        last_n     = last;
        addr_n     = bus_addr;
        we_n       = bus_we;
        wstrb_n    = bus_wstrb;
        wdata_n    = bus_wdata;
        if_rdata_n = if_rdata;
        d_rdata_n  = d_rdata;
        if_ready_n = 1'b0;
        d_ready_n  = 1'b0;
        unique case (state)
            IDLE: begin
                if (if_elig && (!d_elig || last == GNT_D)) begin
                    state_n = FETCH;
                    last_n  = GNT_F;
                    addr_n  = if_addr;
                    we_n    = 1'b0;
                    wstrb_n = 4'b0000;
                    wdata_n = '0;
                end else if (d_elig) begin
                    state_n = DATA;
                    last_n  = GNT_D;
                    addr_n  = d_addr;
                    we_n    = d_we;
                    wstrb_n = d_we ? d_wstrb : 4'b0000;
                    wdata_n = d_wdata;
                end
            end
            FETCH: begin
                if (bus_ready) begin
                    state_n    = IDLE;
                    if_rdata_n = bus_rdata;
                    if_ready_n = 1'b1;
                end
            end
            DATA: begin
                if (bus_ready) begin
                    state_n   = IDLE;
                    d_ready_n = 1'b1;
                    if (!bus_we) begin
                        d_rdata_n = bus_rdata;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            last      <= GNT_F;
            bus_addr  <= '0;
            bus_we    <= 1'b0;
            bus_wstrb <= 4'b0000;
            bus_wdata <= '0;
            if_rdata  <= '0;
            d_rdata   <= '0;
            if_ready  <= 1'b0;
            d_ready   <= 1'b0;
        end else begin
            state     <= state_n;
            last      <= last_n;
            bus_addr  <= addr_n;
            bus_we    <= we_n;
            bus_wstrb <= wstrb_n;
            bus_wdata <= wdata_n;
            if_rdata  <= if_rdata_n;
            d_rdata   <= d_rdata_n;
            if_ready  <= if_ready_n;
            d_ready   <= d_ready_n;
        end
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one external memory bus between the fetch stage (instruction reads) and the memory stage (loads and stores) of the pipelined core.
- Arbitrates between the two, sequences a valid/ready bus transfer, and returns read data to the requester.
- Raises stall requests toward the hazard logic while a requester is waiting.
- Sits between the datapath (PC / ALUResultM / WriteDataM / MemWriteSelect) and a unified memory.

Parameters:
XLEN, 32, data and address width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous reset, active-low: 0 = reset, sampled on rising clk
if_req  in  1  fetch requests an instruction read
if_addr  in  XLEN  fetch address (PC)
if_rdata  out  XLEN  fetched instruction
if_ready  out  1  one-cycle pulse: if_rdata valid, fetch request done
d_req  in  1  memory stage requests an access
d_we  in  1  1 = store, 0 = load
d_wstrb  in  4  byte write strobes (MemWriteSelect)
d_addr  in  XLEN  data address
d_wdata  in  XLEN  store data
d_rdata  out  XLEN  load data
d_ready  out  1  one-cycle pulse: data access done
bus_valid  out  1  transfer request to memory
bus_addr  out  XLEN  transfer address
bus_we  out  1  transfer is write
bus_wstrb  out  4  write strobes, 4'b0000 on reads
bus_wdata  out  XLEN  write data
bus_ready  in  1  memory accepts/completes the transfer this cycle
bus_rdata  in  XLEN  read data, valid when bus_valid & bus_ready
stall_fetch  out  1  fetch waiting
stall_mem  out  1  memory stage waiting

Behaviour:
- Reset (reset==0 at a clk edge):
  - State IDLE; bus_valid, if_ready, d_ready = 0.
  - if_rdata, d_rdata, bus_addr, bus_wdata = 0; bus_we = 0; bus_wstrb = 0.
  - last_grant = FETCH.
  - Applies mid-transfer: the in-flight transfer is abandoned and no ready pulse is issued.
- States:
  - IDLE → FETCH on fetch grant.
  - IDLE → DATA on data grant.
  - FETCH or DATA → IDLE on the cycle with bus_valid & bus_ready.
- Eligibility in IDLE:
  - if_req is eligible only if if_ready == 0 this cycle; d_req is eligible only if d_ready == 0 this cycle. This prevents re-issuing a request that is being acknowledged.
- Grant in IDLE:
  - Only one requester eligible → grant it.
  - Both eligible → grant the one != last_grant (round-robin). After reset, data wins the first tie.
  - last_grant is updated at grant.
- Capture at grant (registered): bus_addr, bus_we, bus_wstrb, bus_wdata are loaded from the granted requester.
  - Fetch: we = 0, wstrb = 0.
  - Load (d_we = 0): wstrb is forced to 0.
  - bus_valid = 1 from the next cycle.
- Bus rule: bus_valid and all bus_* outputs stay stable until the cycle bus_ready == 1. The transfer completes in that cycle.
- Completion:
  - bus_rdata is registered into if_rdata (fetch) or d_rdata (load) on the completion edge. Stores leave d_rdata unchanged.
  - The matching *_ready pulses high for exactly one cycle after completion.
  - *_rdata holds until that requester's next read completes.
- Latency:
  - Request seen in IDLE at cycle N → bus_valid at N+1.
  - bus_ready at N+1 → *_ready at N+2.
  - Minimum 2 cycles; each bus wait cycle adds 1.
  - Minimum back-to-back spacing for one requester is 3 cycles (IDLE, BUS, ready/IDLE).
- Stalls are combinational: stall_fetch = if_req & ~if_ready; stall_mem = d_req & ~d_ready.
- Requester dropping req after grant: the transfer still completes and the ready pulse is still issued. An ungranted request that drops is simply never issued.
- Requests arriving while FETCH or DATA is busy wait in their stall; there is no queue.
- bus_ready while bus_valid == 0 is ignored.

Test Plan:
- Reset then fetch only: reset=0 for 2 cycles, then if_req=1, if_addr=0x0000_0010, bus_ready tied 1, bus_rdata=0x0051_3093.
  - Required: bus_valid high 1 cycle with bus_addr=0x10, bus_we=0.
  - if_ready pulses at +2 with if_rdata=0x0051_3093.
  - stall_fetch high 2 cycles.
- Store with wait states: d_req=1, d_we=1, d_wstrb=4'b0011, d_addr=0x100, d_wdata=0xDEAD_BEEF, bus_ready=0 for 3 cycles then 1.
  - Required: bus_* stable for 4 cycles, bus_wstrb=4'b0011.
  - d_ready pulses once, 5 cycles after the request; d_rdata unchanged.
- Simultaneous requests after reset: if_req=d_req=1 held until each ready.
  - Required: data granted first, then fetch, with no re-issue of data.
  - With both held continuously, grants alternate D, F, D, F.
- Load data return: d_req=1, d_we=0, d_wstrb=4'b1111, bus_rdata=0x1234_5678.
  - Required: bus_wstrb=0 and d_rdata=0x1234_5678 at the d_ready pulse.
- Reset mid-transfer: reset=0 while in FETCH with bus_ready=0.
  - Required: next cycle bus_valid=0, if_ready never pulses, state IDLE, last_grant=FETCH.
- Ready-cycle re-issue guard: keep if_req=1 through its if_ready cycle, then drop it.
  - Required: exactly one bus transfer for that request.
